// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS main control: opcodes, ALUOp codes, states, mux selects.
// Latency: n/a (constants and pure decode helpers only).
// Backpressure: n/a. Optional JAL support is enabled by defining JAL_EN.
package mips_ctrl_pkg;

  // Instruction[31:26] opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef JAL_EN
  localparam logic [5:0] OP_JAL   = 6'b000011;
`endif
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // ALUOp codes; must stay in step with the ALU_control decode
  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;
  localparam logic [2:0] ALUOP_SUB   = 3'b011;
  localparam logic [2:0] ALUOP_AND   = 3'b100;
  localparam logic [2:0] ALUOP_OR    = 3'b101;

  // PCSource selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;  // PC+4 straight from the ALU
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;  // branch target held in ALUOut
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;  // pseudo-direct jump target
  localparam logic [1:0] PCSRC_JR     = 2'b11;  // register value for jr

  // ALUSrcB selects
  localparam logic [1:0] SRCB_REG      = 2'b00;
  localparam logic [1:0] SRCB_FOUR     = 2'b01;
  localparam logic [1:0] SRCB_IMM      = 2'b10;
  localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

  // RegDst / MemtoReg selects
  localparam logic [1:0] DST_RT  = 2'b00;
  localparam logic [1:0] DST_RD  = 2'b01;
  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
`ifdef JAL_EN
  localparam logic [1:0] DST_RA  = 2'b10;  // $31
  localparam logic [1:0] MTR_PC  = 2'b10;  // PC+4 as link value
`endif

  // Control states; 13..15 are unused and recover to FETCH
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11,
    S_JAL       = 4'd12
  } state_t;

  // All datapath controls bundled for a single decode/gate point
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] mem_to_reg;
    logic [1:0] reg_dst;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       illegal_op;
  } ctrl_t;

  // State entered after DECODE; FETCH means the opcode is not supported
  function automatic state_t decode_next(input logic [5:0] op);
    state_t nxt;
    case (op)
      OP_LW, OP_SW:               nxt = S_MEM_ADDR;
      OP_RTYPE:                   nxt = S_R_EXEC;
      OP_BEQ:                     nxt = S_BRANCH;
      OP_J:                       nxt = S_JUMP;
      OP_ADDI, OP_ANDI, OP_ORI:   nxt = S_I_EXEC;
`ifdef JAL_EN
      OP_JAL:                     nxt = S_JAL;
`endif
      default:                    nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

  // ALU operation for the immediate-arithmetic group
  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    logic [2:0] res;
    case (op)
      OP_ANDI: res = ALUOP_AND;
      OP_ORI:  res = ALUOP_OR;
      default: res = ALUOP_ADD;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle main FSM (master) and the MIPS datapath (slave).
// Latency: n/a (wiring only).
// Backpressure: mem_ready from memory stretches FETCH / MEM_READ / MEM_WRITE.
interface multicycle_control_if;
  import mips_ctrl_pkg::*;

  // datapath -> control
  logic [5:0] opcode;
  logic       jr;
  logic       mem_ready;

  // control -> datapath
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] MemtoReg;
  logic [1:0] RegDst;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic [2:0] ALUOp;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, jr, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
           ALUSrcA, MemtoReg, RegDst, ALUSrcB, PCSource, ALUOp, illegal_op, state
  );

  modport slave (
    output opcode, jr, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
           ALUSrcA, MemtoReg, RegDst, ALUSrcB, PCSource, ALUOp, illegal_op, state
  );

endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM: fetch/decode/execute/memory/writeback sequencing (JAL_EN adds jal).
// Latency: lw 5, sw/R/I 4, beq/j/jr/jal 3, illegal 2 cycles with mem_ready high.
// Backpressure: each low mem_ready cycle in FETCH/MEM_READ/MEM_WRITE holds the state one more cycle.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  state_t state_q;
  ctrl_t  ctrl_d;
  ctrl_t  ctrl_o;

  // State register and next-state sequencing; reset aborts any instruction at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:     if (bus.mem_ready) state_q <= S_DECODE;
        S_DECODE:    state_q <= decode_next(bus.opcode);
        S_MEM_ADDR: begin
          if (bus.opcode == OP_LW)      state_q <= S_MEM_READ;
          else if (bus.opcode == OP_SW) state_q <= S_MEM_WRITE;
          else                          state_q <= S_FETCH;
        end
        S_MEM_READ:  if (bus.mem_ready) state_q <= S_MEM_WB;
        S_MEM_WB:    state_q <= S_FETCH;
        S_MEM_WRITE: if (bus.mem_ready) state_q <= S_FETCH;
        S_R_EXEC:    state_q <= bus.jr ? S_FETCH : S_R_WB;
        S_R_WB:      state_q <= S_FETCH;
        S_BRANCH:    state_q <= S_FETCH;
        S_JUMP:      state_q <= S_FETCH;
        S_I_EXEC:    state_q <= S_I_WB;
        S_I_WB:      state_q <= S_FETCH;
`ifdef JAL_EN
        S_JAL:       state_q <= S_FETCH;
`endif
        default:     state_q <= S_FETCH;
      endcase
    end
  end

  // Output decode from the current state; the few input-dependent fields are
  // the mem_ready-qualified PC/IR writes, jr redirect, illegal flag and imm ALUOp
  always_comb begin
    ctrl_d = '0;
    case (state_q)
      S_FETCH: begin
        ctrl_d.mem_read  = 1'b1;
        ctrl_d.alu_src_b = SRCB_FOUR;
        ctrl_d.alu_op    = ALUOP_ADD;
        ctrl_d.pc_source = PCSRC_ALU;
        ctrl_d.ir_write  = bus.mem_ready;
        ctrl_d.pc_write  = bus.mem_ready;
      end
      S_DECODE: begin
        ctrl_d.alu_src_b  = SRCB_IMM_SHL2;
        ctrl_d.alu_op     = ALUOP_ADD;
        ctrl_d.illegal_op = (decode_next(bus.opcode) == S_FETCH);
      end
      S_MEM_ADDR: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = SRCB_IMM;
        ctrl_d.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        ctrl_d.mem_read = 1'b1;
        ctrl_d.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_to_reg = MTR_MEM;
        ctrl_d.reg_dst    = DST_RT;
      end
      S_MEM_WRITE: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = SRCB_REG;
        ctrl_d.alu_op    = ALUOP_FUNCT;
        if (bus.jr) begin
          ctrl_d.pc_write  = 1'b1;
          ctrl_d.pc_source = PCSRC_JR;
        end
      end
      S_R_WB: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.reg_dst    = DST_RD;
        ctrl_d.mem_to_reg = MTR_ALU;
      end
      S_BRANCH: begin
        ctrl_d.alu_src_a     = 1'b1;
        ctrl_d.alu_src_b     = SRCB_REG;
        ctrl_d.alu_op        = ALUOP_SUB;
        ctrl_d.pc_write_cond = 1'b1;
        ctrl_d.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl_d.pc_write  = 1'b1;
        ctrl_d.pc_source = PCSRC_JUMP;
      end
      S_I_EXEC: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = SRCB_IMM;
        ctrl_d.alu_op    = imm_alu_op(bus.opcode);
      end
      S_I_WB: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.reg_dst    = DST_RT;
        ctrl_d.mem_to_reg = MTR_ALU;
      end
`ifdef JAL_EN
      S_JAL: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.reg_dst    = DST_RA;
        ctrl_d.mem_to_reg = MTR_PC;
        ctrl_d.pc_write   = 1'b1;
        ctrl_d.pc_source  = PCSRC_JUMP;
      end
`endif
      default: ctrl_d = '0;
    endcase
  end

  // Reset overrides every control combinationally so no write survives into reset
  assign ctrl_o = reset ? '0 : ctrl_d;

  assign bus.PCWrite     = ctrl_o.pc_write;
  assign bus.PCWriteCond = ctrl_o.pc_write_cond;
  assign bus.IorD        = ctrl_o.i_or_d;
  assign bus.MemRead     = ctrl_o.mem_read;
  assign bus.MemWrite    = ctrl_o.mem_write;
  assign bus.IRWrite     = ctrl_o.ir_write;
  assign bus.RegWrite    = ctrl_o.reg_write;
  assign bus.ALUSrcA     = ctrl_o.alu_src_a;
  assign bus.MemtoReg    = ctrl_o.mem_to_reg;
  assign bus.RegDst      = ctrl_o.reg_dst;
  assign bus.ALUSrcB     = ctrl_o.alu_src_b;
  assign bus.PCSource    = ctrl_o.pc_source;
  assign bus.ALUOp       = ctrl_o.alu_op;
  assign bus.illegal_op  = ctrl_o.illegal_op;
  assign bus.state       = state_q;

endmodule
